// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect response path.
// Contents:
//   BRESP_*     : AXI write-response codes
//   ARB_FIXED/RR: arbitration mode selectors for rr_arbiter
//   buf_state_t : occupancy of a one-entry response buffer
package axi_ic_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/axi_wresp_rr_arbiter_if.sv
// B-channel bundle between NUM_SLAVES slave ports and NUM_MASTERS master ports.
// Signals:
//   s_bvalid/s_bid/s_bresp : per-slave responses (slave i at [i*ID_W +: ID_W] / [i*2 +: 2])
//   s_bready               : per-slave ready, one-hot or zero
//   m_bvalid               : per-master valid, one-hot or zero
//   m_bid/m_bresp          : response fields shared by all masters
//   m_bready               : per-master ready
// Modports:
//   master : the arbiter's view (drives the readies toward slaves and valids toward masters)
//   slave  : the surrounding ports' view (drives responses and master readies)
interface axi_wresp_rr_arbiter_if #(
  parameter int NUM_SLAVES  = 4,
  parameter int NUM_MASTERS = 2,
  parameter int ID_W        = $clog2(NUM_MASTERS)
);

  logic [NUM_SLAVES-1:0]      s_bvalid;
  logic [NUM_SLAVES*ID_W-1:0] s_bid;
  logic [NUM_SLAVES*2-1:0]    s_bresp;
  logic [NUM_SLAVES-1:0]      s_bready;
  logic [NUM_MASTERS-1:0]     m_bvalid;
  logic [ID_W-1:0]            m_bid;
  logic [1:0]                 m_bresp;
  logic [NUM_MASTERS-1:0]     m_bready;

  modport master (
    input  s_bvalid, s_bid, s_bresp, m_bready,
    output s_bready, m_bvalid, m_bid, m_bresp
  );

  modport slave (
    output s_bvalid, s_bid, s_bresp, m_bready,
    input  s_bready, m_bvalid, m_bid, m_bresp
  );

endinterface

// File: rtl/rr_arbiter.sv
// N-way request arbiter, fixed-priority or round-robin.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req       : request vector
//   advance   : the consumer takes the current grant this cycle (moves the pointer)
//   grant     : one-hot grant (zero when no request)
//   grant_idx : binary index of the granted requester
//   any       : at least one request is present
// The grant depends only on req and the pointer, so a consumer may gate it
// with its own ready without forming a loop.
module rr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = ARB_RR,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Pointer holds the lowest-priority index; reset to N-1 so index 0 wins first.
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  assign any = |req;

  // Fixed mode scans 0..N-1; round-robin scans ptr+1, ptr+2, ... with wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == ARB_FIXED) begin
        cand = IDX_W'(k);
      end else begin
        cand = IDX_W'((int'(ptr) + 1 + k) % N);
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(N - 1);
    end else if (advance && any) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/axi_wresp_rr_arbiter.sv
// Write-response arbiter: picks one slave B response per cycle, holds it in a
// one-entry buffer and routes it to the master indexed by its BID.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : B-channel bundle (master modport), see axi_wresp_rr_arbiter_if
//   sel_slave  : index of the slave whose response sits in the buffer
//   err_decode : one-cycle pulse after a response with BID >= NUM_MASTERS is dropped
module axi_wresp_rr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int NUM_MASTERS = 2,
  parameter int ID_W        = $clog2(NUM_MASTERS),
  parameter int ARB_MODE    = ARB_RR,
  localparam int SEL_W = $clog2(NUM_SLAVES)
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_wresp_rr_arbiter_if.master bus,
  output logic [SEL_W-1:0]      sel_slave,
  output logic                  err_decode
);

  buf_state_t       state_q, state_d;
  logic [ID_W-1:0]  buf_bid;
  logic [1:0]       buf_bresp;
  logic [SEL_W-1:0] buf_sel;
  logic             err_q, err_d;

  logic                  buf_ready;
  logic                  load_en;
  logic                  advance;
  logic                  load;
  logic [NUM_SLAVES-1:0] grant;
  logic [SEL_W-1:0]      grant_idx;
  logic                  any;
  logic [ID_W-1:0]       grant_bid;
  logic [1:0]            grant_bresp;
  logic                  bid_ok;

  // Ready of the master the buffered response is addressed to; other masters' readies are ignored.
  always_comb begin
    buf_ready = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (buf_bid == ID_W'(i)) begin
        buf_ready = bus.m_bready[i];
      end
    end
  end

  // The buffer can take a new response when empty or when it drains this cycle.
  assign load_en = (state_q == EMPTY) || buf_ready;
  assign advance = load_en && !rst;

  rr_arbiter #(
    .N    (NUM_SLAVES),
    .MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.s_bvalid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // The only combinational path from m_bready: through load_en to s_bready.
  assign bus.s_bready = advance ? grant : '0;

  assign grant_bid   = bus.s_bid[int'(grant_idx)*ID_W +: ID_W];
  assign grant_bresp = bus.s_bresp[int'(grant_idx)*2 +: 2];

  // One extra bit keeps the compare meaningful when NUM_MASTERS == 2**ID_W.
  assign bid_ok = ({1'b0, grant_bid} < (ID_W+1)'(NUM_MASTERS));

  // A granted response with an undecodable BID is still acknowledged to the
  // slave, but dropped instead of buffered, and flagged one cycle later.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    err_d   = 1'b0;
    if (advance) begin
      if (any) begin
        if (bid_ok) begin
          state_d = FULL;
          load    = 1'b1;
        end else begin
          state_d = EMPTY;
          err_d   = 1'b1;
        end
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      buf_bid   <= '0;
      buf_bresp <= BRESP_OKAY;
      buf_sel   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (load) begin
        buf_bid   <= grant_bid;
        buf_bresp <= grant_bresp;
        buf_sel   <= grant_idx;
      end
    end
  end

  // Master-side outputs come straight from registers.
  always_comb begin
    bus.m_bvalid = '0;
    if (state_q == FULL) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (buf_bid == ID_W'(i)) begin
          bus.m_bvalid[i] = 1'b1;
        end
      end
    end
  end

  assign bus.m_bid   = buf_bid;
  assign bus.m_bresp = buf_bresp;
  assign sel_slave   = buf_sel;
  assign err_decode  = err_q;

endmodule

// File: tb/tb_axi_wresp_rr_arbiter.sv
// Testbench for axi_wresp_rr_arbiter.
// dut_a: 4 slaves, 2 masters, round-robin.
// dut_b: 4 slaves, 3 masters (ID_W=2), fixed priority.
// Stimulus pushes each expected accepted response into a per-DUT queue;
// monitors pop and compare whenever a master handshake is presented.
module tb_axi_wresp_rr_arbiter;
  import axi_ic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  axi_wresp_rr_arbiter_if #(.NUM_SLAVES(4), .NUM_MASTERS(2), .ID_W(1)) ifa ();
  axi_wresp_rr_arbiter_if #(.NUM_SLAVES(4), .NUM_MASTERS(3), .ID_W(2)) ifb ();

  logic [1:0] sel_a, sel_b;
  logic       err_a, err_b;

  axi_wresp_rr_arbiter #(
    .NUM_SLAVES(4), .NUM_MASTERS(2), .ID_W(1), .ARB_MODE(ARB_RR)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .sel_slave(sel_a), .err_decode(err_a)
  );

  axi_wresp_rr_arbiter #(
    .NUM_SLAVES(4), .NUM_MASTERS(3), .ID_W(2), .ARB_MODE(ARB_FIXED)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .sel_slave(sel_b), .err_decode(err_b)
  );

  typedef struct packed {
    logic [2:0] mvalid;
    logic [1:0] bid;
    logic [1:0] bresp;
    logic [1:0] sel;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // dutSel 0 -> dut_a, 1 -> dut_b; bid is packed in the DUT's own s_bid layout.
  task automatic applyStimulus(input int dutSel, input logic [3:0] valid, input logic [7:0] bid,
                               input logic [7:0] bresp, input logic [2:0] ready);
    if (dutSel == 0) begin
      ifa.s_bvalid = valid;
      ifa.s_bid    = bid[3:0];
      ifa.s_bresp  = bresp;
      ifa.m_bready = ready[1:0];
    end else begin
      ifb.s_bvalid = valid;
      ifb.s_bid    = bid;
      ifb.s_bresp  = bresp;
      ifb.m_bready = ready;
    end
  endtask

  task automatic expectResp(input int dutSel, input logic [2:0] mv, input logic [1:0] bid,
                            input logic [1:0] bresp, input logic [1:0] sel);
    exp_t e;
    e = '{mvalid: mv, bid: bid, bresp: bresp, sel: sel};
    if (dutSel == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outsA();
    return 32'({ifa.s_bready, ifa.m_bvalid, ifa.m_bid, ifa.m_bresp, sel_a, err_a});
  endfunction

  function automatic logic [31:0] outsB();
    return 32'({ifb.s_bready, ifb.m_bvalid, ifb.m_bid, ifb.m_bresp, sel_b, err_b});
  endfunction

  // Monitors: compare every response a master actually accepts.
  always @(negedge clk) begin
    if (!rst && (ifa.m_bvalid & ifa.m_bready) != 2'b00) begin
      if (qa.size() == 0) begin
        checkOutput("A.unexpected_resp", 32'(ifa.m_bvalid), 32'd0);
      end else begin
        ea = qa.pop_front();
        checkOutput("A.resp", 32'({1'b0, ifa.m_bvalid, 1'b0, ifa.m_bid, ifa.m_bresp, sel_a}), 32'(ea));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (ifb.m_bvalid & ifb.m_bready) != 3'b000) begin
      if (qb.size() == 0) begin
        checkOutput("B.unexpected_resp", 32'(ifb.m_bvalid), 32'd0);
      end else begin
        eb = qb.pop_front();
        checkOutput("B.resp", 32'({ifb.m_bvalid, ifb.m_bid, ifb.m_bresp, sel_b}), 32'(eb));
      end
    end
  end

  int rrSeq[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int g;
    applyStimulus(0, 4'b0, 8'h00, 8'h00, 3'b000);
    applyStimulus(1, 4'b0, 8'h00, 8'h00, 3'b000);
    rst = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    checkOutput("A.reset_outputs", outsA(), 32'd0);
    checkOutput("B.reset_outputs", outsB(), 32'd0);
    nextCycle();
    rst = 1'b0;

    // Round-robin: all slaves valid, slave i carries bid=i%2, bresp=i
    $display("[TB] round-robin rotation");
    applyStimulus(0, 4'b1111, 8'b1010, 8'b11_10_01_00, 3'b011);
    for (int k = 0; k < 6; k++) begin
      g = rrSeq[k];
      expectResp(0, 3'(1 << (g % 2)), 2'(g % 2), 2'(g), 2'(g));
      @(negedge clk);
      checkOutput($sformatf("A.rr_sready[%0d]", k), 32'(ifa.s_bready), 32'(4'b0001 << g));
      nextCycle();
    end
    applyStimulus(0, 4'b0, 8'h00, 8'h00, 3'b011);
    @(negedge clk);
    nextCycle();

    // Single response: slave 2, bid=1, SLVERR
    $display("[TB] single response");
    applyStimulus(0, 4'b0100, 8'b0100, 8'h20, 3'b011);
    expectResp(0, 3'b010, 2'd1, BRESP_SLVERR, 2'd2);
    @(negedge clk);
    checkOutput("A.single_sready", 32'(ifa.s_bready), 32'(4'b0100));
    nextCycle();
    applyStimulus(0, 4'b0, 8'h00, 8'h00, 3'b011);
    @(negedge clk);
    checkOutput("A.single_out", 32'({ifa.m_bvalid, ifa.m_bresp, sel_a}), 32'({2'b10, 2'b10, 2'd2}));
    nextCycle();

    // Backpressure: slave 3 -> master 0 held while m_bready[0]=0, slave 0 waiting
    $display("[TB] backpressure");
    applyStimulus(0, 4'b1000, 8'b0000, 8'h40, 3'b010);
    expectResp(0, 3'b001, 2'd0, BRESP_EXOKAY, 2'd3);
    @(negedge clk);
    checkOutput("A.bp_load_sready", 32'(ifa.s_bready), 32'(4'b1000));
    nextCycle();
    applyStimulus(0, 4'b0001, 8'b0001, 8'h03, 3'b010);
    expectResp(0, 3'b010, 2'd1, BRESP_DECERR, 2'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("A.bp_hold[%0d]", k),
                  32'({ifa.s_bready, ifa.m_bvalid, ifa.m_bid, ifa.m_bresp, sel_a}),
                  32'({4'b0000, 2'b01, 1'b0, 2'b01, 2'd3}));
      nextCycle();
    end
    applyStimulus(0, 4'b0001, 8'b0001, 8'h03, 3'b011);
    @(negedge clk);
    checkOutput("A.bp_drain_reload_sready", 32'(ifa.s_bready), 32'(4'b0001));
    nextCycle();
    applyStimulus(0, 4'b0, 8'h00, 8'h00, 3'b011);
    @(negedge clk);
    nextCycle();

    // Fixed priority: slaves 1 (bid=2) and 3 (bid=0, SLVERR) both valid
    $display("[TB] fixed priority");
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1, 4'b1010, 8'h08, 8'h80 | 8'(j << 2), 3'b111);
      expectResp(1, 3'b100, 2'd2, 2'(j), 2'd1);
      @(negedge clk);
      checkOutput($sformatf("B.fixed_sready[%0d]", j), 32'(ifb.s_bready), 32'(4'b0010));
      nextCycle();
    end
    applyStimulus(1, 4'b1000, 8'h08, 8'h80, 3'b111);
    expectResp(1, 3'b001, 2'd0, BRESP_SLVERR, 2'd3);
    @(negedge clk);
    checkOutput("B.fixed_slave3_sready", 32'(ifb.s_bready), 32'(4'b1000));
    nextCycle();
    applyStimulus(1, 4'b0, 8'h00, 8'h00, 3'b111);
    @(negedge clk);
    nextCycle();

    // Bad BID: slave 1 sends bid=3 with only 3 masters
    $display("[TB] bad bid");
    applyStimulus(1, 4'b0010, 8'h0C, 8'h00, 3'b111);
    @(negedge clk);
    checkOutput("B.badbid_sready", 32'(ifb.s_bready), 32'(4'b0010));
    checkOutput("B.badbid_err_early", 32'(err_b), 32'd0);
    nextCycle();
    applyStimulus(1, 4'b0, 8'h00, 8'h00, 3'b111);
    @(negedge clk);
    checkOutput("B.badbid_mvalid", 32'(ifb.m_bvalid), 32'd0);
    checkOutput("B.badbid_err", 32'(err_b), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("B.badbid_err_clear", 32'(err_b), 32'd0);
    nextCycle();

    // Reset mid-operation on dut_a: buffered slave-1 response is discarded
    $display("[TB] reset mid-operation");
    applyStimulus(0, 4'b0010, 8'b0000, 8'h08, 3'b000);
    @(negedge clk);
    checkOutput("A.rst_load_sready", 32'(ifa.s_bready), 32'(4'b0010));
    nextCycle();
    applyStimulus(0, 4'b0001, 8'b0001, 8'h00, 3'b000);
    @(negedge clk);
    checkOutput("A.rst_full_state", 32'({ifa.s_bready, ifa.m_bvalid}), 32'({4'b0000, 2'b01}));
    nextCycle();
    rst = 1'b1;
    applyStimulus(0, 4'b0001, 8'b0001, 8'h00, 3'b001);
    @(negedge clk);
    checkOutput("A.rst_sready_forced", 32'(ifa.s_bready), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("A.rst_outputs", outsA(), 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 4'b1001, 8'b0001, 8'h40, 3'b011);
    expectResp(0, 3'b010, 2'd1, BRESP_OKAY, 2'd0);
    @(negedge clk);
    checkOutput("A.after_rst_sready", 32'(ifa.s_bready), 32'(4'b0001));
    nextCycle();
    applyStimulus(0, 4'b1000, 8'b0001, 8'h40, 3'b011);
    expectResp(0, 3'b001, 2'd0, BRESP_EXOKAY, 2'd3);
    @(negedge clk);
    checkOutput("A.after_rst_second_sready", 32'(ifa.s_bready), 32'(4'b1000));
    nextCycle();
    applyStimulus(0, 4'b0, 8'h00, 8'h00, 3'b011);

    // Let outstanding expectations drain, bounded
    for (int w = 0; w < 20 && (qa.size() != 0 || qb.size() != 0); w++) begin
      nextCycle();
    end
    checkOutput("A.queue_drained", 32'(qa.size()), 32'd0);
    checkOutput("B.queue_drained", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
